// File: rtl/bram_frame_writer_pkg.sv
// Shared frame geometry, address packing and writer FSM encoding.
// Also imported by the display reader so both sides agree on layout.
package bram_frame_writer_pkg;

  localparam int FRAME_W_DEF = 640;
  localparam int FRAME_H_DEF = 480;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int ADDR_W = X_W + Y_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_SOF,
    ST_WRITE
  } state_t;

  function automatic logic [ADDR_W-1:0] pack_addr(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/bram_frame_writer_raster.sv
// Raster position counter: x/y with line wrap, restart and last flag.
// Shared by the clear sweep and the pixel capture path.
module raster_counter
  import bram_frame_writer_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int FRAME_H = FRAME_H_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           sof,
  input  logic           step,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W-1:0] X_MAX = X_W'(FRAME_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(FRAME_H - 1);

  assign last = (x == X_MAX) && (y == Y_MAX);

  // sof restarts at (1,0) because (0,0) is written by the sof pixel itself
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (sof) begin
      x <= X_W'(1);
      y <= '0;
    end else if (step) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/bram_frame_writer.sv
// Binary frame writer into a 1-bit BRAM: raster capture and zero-fill.
// Write port outputs are registered, one cycle after acceptance.
module bram_frame_writer
  import bram_frame_writer_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int FRAME_H = FRAME_H_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic              clear_req,
  input  logic              pix_valid,
  input  logic              pix_data,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic              bram_write_data,
  output logic              busy,
  output logic              frame_done,
  output logic              sync_err
);

  state_t state, state_nxt;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic last;
  logic cnt_clr, cnt_sof, cnt_step;
  logic accept;

  logic              we_nxt;
  logic              data_nxt;
  logic              done_nxt;
  logic              err_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  raster_counter #(
    .FRAME_W(FRAME_W),
    .FRAME_H(FRAME_H)
  ) u_raster (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .sof  (cnt_sof),
    .step (cnt_step),
    .x    (x),
    .y    (y),
    .last (last)
  );

  assign pix_ready = (state == ST_WAIT_SOF) || (state == ST_WRITE);
  assign busy      = (state != ST_IDLE);
  assign accept    = pix_valid && pix_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_sof   = 1'b0;
    cnt_step  = 1'b0;
    we_nxt    = 1'b0;
    data_nxt  = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    addr_nxt  = pack_addr(x, y);
    unique case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (clear_req)    state_nxt = ST_CLEAR;
        else if (capture) state_nxt = ST_WAIT_SOF;
      end
      ST_CLEAR: begin
        we_nxt = 1'b1;
        if (last) begin
          done_nxt  = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_step = 1'b1;
        end
      end
      ST_WAIT_SOF: begin
        if (accept && pix_sof) begin
          we_nxt    = 1'b1;
          data_nxt  = pix_data;
          addr_nxt  = '0;
          cnt_sof   = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          we_nxt   = 1'b1;
          data_nxt = pix_data;
          if (pix_sof) begin
            err_nxt  = 1'b1;
            addr_nxt = '0;
            cnt_sof  = 1'b1;
          end else if (last) begin
            done_nxt  = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            cnt_step = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // address and data hold their last value between writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bram_we         <= 1'b0;
      bram_addr       <= '0;
      bram_write_data <= 1'b0;
      frame_done      <= 1'b0;
      sync_err        <= 1'b0;
    end else begin
      bram_we    <= we_nxt;
      frame_done <= done_nxt;
      sync_err   <= err_nxt;
      if (we_nxt) begin
        bram_addr       <= addr_nxt;
        bram_write_data <= data_nxt;
      end
    end
  end

endmodule

// File: doc/bram_frame_writer.md
BRAM_FRAME_WRITER -- requirements
Module: bram_frame_writer

Interface
REQ-001: Parameter FRAME_W, default 640, active pixels per line.
REQ-002: Parameter FRAME_H, default 480, active lines per frame.
REQ-003: clk  input  1  system clock; all state changes on its rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: capture  input  1  one-cycle pulse that arms capture of the next frame.
REQ-006: clear_req  input  1  one-cycle pulse that requests a zero-fill of the whole frame.
REQ-007: pix_valid  input  1  upstream pixel valid.
REQ-008: pix_data  input  1  binary pixel, 1 = foreground.
REQ-009: pix_sof  input  1  marks the first pixel of a frame; qualified by pix_valid.
REQ-010: pix_ready  output  1  pixel accepted on any cycle where pix_valid && pix_ready.
REQ-011: bram_addr  output  19  write address {y[8:0], x[9:0]}.
REQ-012: bram_we  output  1  write enable to the 1-bit frame BRAM port.
REQ-013: bram_write_data  output  1  write data.
REQ-014: busy  output  1  high in any state other than IDLE.
REQ-015: frame_done  output  1  one-cycle pulse when a capture or a clear completes.
REQ-016: sync_err  output  1  one-cycle pulse on a mid-frame pix_sof.

Function
REQ-017: The FSM SHALL have states IDLE, CLEAR, WAIT_SOF and WRITE.
REQ-018: In IDLE, clear_req SHALL go to CLEAR; otherwise capture SHALL go to WAIT_SOF; when both are asserted together, clear wins and capture is dropped.
REQ-019: capture and clear_req SHALL be ignored outside IDLE.
REQ-020: pix_ready SHALL be 1 only in WAIT_SOF and WRITE, and 0 in IDLE and CLEAR.
REQ-021: In WAIT_SOF, accepted pixels without pix_sof SHALL be discarded with no write.
- An accepted pixel with pix_sof is written at (0,0), and the FSM goes to WRITE with the next position (1,0).
REQ-022: In WRITE, each accepted pixel SHALL be written at the current (x,y).
- x increments after each write.
- At x = FRAME_W-1, x wraps to 0 and y increments.
REQ-023: Writing (FRAME_W-1, FRAME_H-1) SHALL end the capture: frame_done pulses and the FSM returns to IDLE.
REQ-024: An accepted pix_sof in WRITE SHALL pulse sync_err, write that pixel at (0,0), and continue from (1,0).
REQ-025: In CLEAR, one address SHALL be written with 0 per cycle, raster order, (0,0) through (FRAME_W-1, FRAME_H-1).
- This takes FRAME_W*FRAME_H cycles.
- frame_done pulses with the last write, then the FSM returns to IDLE.
REQ-026: Write latency SHALL be one cycle: bram_addr, bram_we and bram_write_data are registered and valid the cycle after acceptance.
REQ-027: Addresses with x >= FRAME_W or y >= FRAME_H SHALL never be written.
REQ-028: bram_we SHALL be 0 on every cycle with no accepted pixel or clear step, and bram_addr holds its last value.
REQ-029: The x counter SHALL be 10 bits and the y counter 9 bits, zero-extended into the address, with no arithmetic overflow.

Reset
REQ-030: Asserting reset SHALL immediately force:
- FSM to IDLE, x = y = 0;
- bram_addr = 0, bram_we = 0, bram_write_data = 0;
- pix_ready = 0, busy = 0, frame_done = 0, sync_err = 0.
REQ-031: Reset mid-CLEAR or mid-WRITE SHALL abort without frame_done; partially written BRAM contents are undefined.

Structure
REQ-032: A shared package SHALL hold FRAME_W/FRAME_H defaults, the 19-bit address width, and the FSM state encoding; the downstream display reader uses the same package.
REQ-033: The raster position counter (x/y with wrap, restart, last-pixel flag) SHALL be a sub-module named raster_counter, shared by CLEAR and WRITE.

Verification
REQ-034: Bench SHALL cover: reset, then clear_req -> 307200 consecutive cycles with bram_we=1 and data 0; the first address is 0x00000, the last is {9'd479, 10'd639} = 0x77E7F; frame_done pulses once, busy then falls.
REQ-035: Bench SHALL cover: capture, two non-sof pixels, then a full 640x480 frame with sof, valid always high -> no writes for the two discarded pixels; pixel n is written at {n/640, n%640} one cycle after acceptance; frame_done follows the last pixel.
REQ-036: Bench SHALL cover: capture with random pix_valid gaps -> writes only on accepted cycles, addresses contiguous, bram_we=0 in the gaps.
REQ-037: Bench SHALL cover: pix_sof at pixel 1000 of a capture -> sync_err pulses once; that pixel is written at address 0 and the next at address 1.
REQ-038: Bench SHALL cover: capture and clear_req asserted in the same cycle -> CLEAR runs and pix_ready stays 0; afterwards the FSM is in IDLE, not WAIT_SOF.
REQ-039: Bench SHALL cover: reset at pixel 5000 of a capture -> all outputs go to 0 asynchronously, the FSM is in IDLE, and no frame_done is seen.
